// File: rtl/riscv_mpsoc_pkg.sv
// Shared Wishbone cycle-type / burst-type codes and the bridge FSM state type.
package riscv_mpsoc_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_ACK   = 2'd1,
        WB_BURST = 2'd2,
        WB_ERR   = 2'd3
    } wb_state_t;

    // Index bits that rotate inside a wrapping burst; linear bursts use the full increment.
    function automatic logic [3:0] bte_mask(input logic [1:0] bte);
        logic [3:0] m;
        case (bte)
            BTE_WRAP4:  m = 4'b0011;
            BTE_WRAP8:  m = 4'b0111;
            BTE_WRAP16: m = 4'b1111;
            default:    m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/riscv_wb2mem_if.sv
// Wishbone B3 bus between the BIU master and the SRAM bridge.
interface riscv_wb2mem_if #(
    parameter int XLEN = 64,
    parameter int PLEN = 64
);
    // A beat transfers on a cycle where cyc & stb are high and the slave answers with
    // ack (or err); the master holds adr/dat/sel/we/cti/bte stable until that answer.
    logic [PLEN-1:0]   wb_adr_i;
    logic [XLEN-1:0]   wb_dat_i;
    logic [XLEN/8-1:0] wb_sel_i;
    logic              wb_we_i;
    logic              wb_cyc_i;
    logic              wb_stb_i;
    logic [2:0]        wb_cti_i;
    logic [1:0]        wb_bte_i;
    logic [XLEN-1:0]   wb_dat_o;
    logic              wb_ack_o;
    logic              wb_err_o;
    logic              wb_rty_o;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
        output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
        input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );

endinterface

// File: rtl/riscv_wb_burst_addr.sv
// Next SRAM word index of a Wishbone burst: linear increment or wrap within a 4/8/16 block.
module riscv_wb_burst_addr
    import riscv_mpsoc_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [1:0]            bte,
    output logic [DEPTH_LOG2-1:0] nxt_idx
);

    logic [DEPTH_LOG2-1:0] inc;
    logic [DEPTH_LOG2-1:0] mask;

    assign inc  = idx + DEPTH_LOG2'(1);
    assign mask = DEPTH_LOG2'(bte_mask(bte));

    always_comb begin
        nxt_idx = inc;
        if (bte != BTE_LINEAR) begin
            nxt_idx = (idx & ~mask) | (inc & mask);
        end
    end

endmodule

// File: rtl/riscv_wb2mem.sv
// Wishbone B3 slave terminating single and burst transfers onto a single-port synchronous SRAM.
module riscv_wb2mem
    import riscv_mpsoc_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int PLEN       = 64,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  HRESETn,
    input  logic                  HCLK,
    riscv_wb2mem_if.slave         wb,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [DEPTH_LOG2-1:0] mem_adr_o,
    output logic [XLEN/8-1:0]     mem_be_o,
    output logic [XLEN-1:0]       mem_d_o,
    input  logic [XLEN-1:0]       mem_q_i,
    output wb_state_t             dbg_state
);

    localparam int ALSB = $clog2(XLEN / 8);

    wb_state_t             state;
    wb_state_t             state_nxt;
    logic [DEPTH_LOG2-1:0] idx;
    logic [DEPTH_LOG2-1:0] idx_nxt;
    logic [DEPTH_LOG2-1:0] burst_idx;
    logic [DEPTH_LOG2-1:0] adr_idx;
    logic                  req;
    logic                  adr_in_range;
    logic                  burst_oor;
    logic                  ack;
    logic                  err;
    logic                  m_req;
    logic                  m_we;
    logic [DEPTH_LOG2-1:0] m_adr;
    logic [XLEN/8-1:0]     m_be;
    logic                  unused_adr_lsb;

    assign req            = wb.wb_cyc_i & wb.wb_stb_i;
    assign adr_idx        = wb.wb_adr_i[ALSB +: DEPTH_LOG2];
    assign adr_in_range   = (wb.wb_adr_i[PLEN-1:ALSB+DEPTH_LOG2] == '0);
    assign unused_adr_lsb = ^wb.wb_adr_i[ALSB-1:0];

    // Only a linear burst can step off the top of the array; wrapping keeps the upper bits.
    assign burst_oor = (wb.wb_bte_i == BTE_LINEAR) && (&idx);

    riscv_wb_burst_addr #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_burst_addr (
        .idx    (idx),
        .bte    (wb.wb_bte_i),
        .nxt_idx(burst_idx)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= WB_IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        ack       = 1'b0;
        err       = 1'b0;
        m_req     = 1'b0;
        m_we      = 1'b0;
        m_adr     = idx;
        m_be      = '0;

        case (state)
            WB_IDLE: begin
                if (req) begin
                    if (adr_in_range) begin
                        state_nxt = WB_ACK;
                        idx_nxt   = adr_idx;
                        m_adr     = adr_idx;
                        m_req     = !wb.wb_we_i;
                    end else begin
                        state_nxt = WB_ERR;
                    end
                end
            end

            WB_ACK, WB_BURST: begin
                state_nxt = WB_IDLE;
                if (req) begin
                    ack = 1'b1;
                    if (wb.wb_we_i) begin
                        m_req = 1'b1;
                        m_we  = 1'b1;
                        m_be  = wb.wb_sel_i;
                    end
                    if (wb.wb_cti_i == CTI_INCR) begin
                        if (burst_oor) begin
                            state_nxt = WB_ERR;
                        end else begin
                            state_nxt = WB_BURST;
                            idx_nxt   = burst_idx;
                            // Fetch the next read beat now so it can be acked without a wait state.
                            if (!wb.wb_we_i) begin
                                m_req = 1'b1;
                                m_adr = burst_idx;
                            end
                        end
                    end
                end
            end

            WB_ERR: begin
                err       = req;
                state_nxt = WB_IDLE;
            end

            default: begin
                state_nxt = WB_IDLE;
            end
        endcase
    end

    // Outputs are forced low while reset is held so a live request cannot reach the SRAM.
    assign wb.wb_ack_o = ack & HRESETn;
    assign wb.wb_err_o = err & HRESETn;
    assign wb.wb_rty_o = 1'b0;
    assign wb.wb_dat_o = (wb.wb_ack_o && !wb.wb_we_i) ? mem_q_i : '0;

    assign mem_req_o = m_req & HRESETn;
    assign mem_we_o  = m_we & HRESETn;
    assign mem_adr_o = HRESETn ? m_adr : '0;
    assign mem_be_o  = HRESETn ? m_be : '0;
    assign mem_d_o   = mem_we_o ? wb.wb_dat_i : '0;
    assign dbg_state = state;

    ack_err_exclusive: assert property (@(posedge HCLK) disable iff (!HRESETn)
        !(wb.wb_ack_o && wb.wb_err_o));

endmodule

// File: tb/tb_riscv_wb2mem.sv
// Bench for riscv_wb2mem: table vectors, hand-written burst corners and random bursts vs a word-level model.
module tb_riscv_wb2mem;
    import riscv_mpsoc_pkg::*;

    localparam int XLEN  = 64;
    localparam int PLEN  = 32;
    localparam int DL    = 6;
    localparam int DEPTH = 64;
    localparam int SW    = 8;

    // ---------------- clock / reset ----------------
    logic HCLK = 1'b0;
    logic HRESETn;
    always #5 HCLK = ~HCLK;

    riscv_wb2mem_if #(.XLEN(XLEN), .PLEN(PLEN)) wb_if ();

    logic            mem_req;
    logic            mem_we;
    logic [DL-1:0]   mem_adr;
    logic [SW-1:0]   mem_be;
    logic [XLEN-1:0] mem_d;
    logic [XLEN-1:0] mem_q;
    wb_state_t       dbg_state;

    riscv_wb2mem #(.XLEN(XLEN), .PLEN(PLEN), .DEPTH_LOG2(DL)) dut (
        .HRESETn  (HRESETn),
        .HCLK     (HCLK),
        .wb       (wb_if.slave),
        .mem_req_o(mem_req),
        .mem_we_o (mem_we),
        .mem_adr_o(mem_adr),
        .mem_be_o (mem_be),
        .mem_d_o  (mem_d),
        .mem_q_i  (mem_q),
        .dbg_state(dbg_state)
    );

    // ---------------- SRAM environment ----------------
    logic [XLEN-1:0] sram [DEPTH];
    logic            do_preload;
    int              rd_count;
    int              wr_count;

    function automatic logic [63:0] pre_val(input int i);
        if (i == 3) return 64'h0000_0000_DEAD_BEEF;
        return {32'hC0DE_0000 + 32'(i), 32'h5A5A_0000 + 32'(i)};
    endfunction

    always @(posedge HCLK) begin
        if (do_preload) begin
            for (int i = 0; i < DEPTH; i++) sram[i] <= pre_val(i);
            mem_q    <= '0;
            rd_count <= 0;
            wr_count <= 0;
        end else if (mem_req) begin
            if (mem_we) begin
                for (int k = 0; k < SW; k++)
                    if (mem_be[k]) sram[mem_adr][8*k +: 8] <= mem_d[8*k +: 8];
                wr_count <= wr_count + 1;
            end else begin
                mem_q    <= sram[mem_adr];
                rd_count <= rd_count + 1;
            end
        end
    end

    // ---------------- scoreboard / model ----------------
    logic [XLEN-1:0] exp_q[$];
    logic [63:0]     model_mem [DEPTH];
    int              checks   = 0;
    int              failures = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Word index following w in a burst; may exceed DEPTH for a linear burst.
    function automatic int next_word(input int w, input logic [1:0] b);
        int n;
        if (b == BTE_LINEAR) return w + 1;
        n = 2 << b;
        return (w / n) * n + (w + 1) % n;
    endfunction

    // ---------------- driver ----------------
    task automatic set_beat(input int w, input logic [63:0] d, input logic [7:0] s, input logic [2:0] c);
        wb_if.wb_adr_i = 32'(w * 8);
        wb_if.wb_dat_i = d;
        wb_if.wb_sel_i = s;
        wb_if.wb_cti_i = c;
    endtask

    task automatic run_burst(input string nm, input logic we_v, input logic [PLEN-1:0] adr0,
                             input logic [1:0] bte_v, input int beats, input int drop_after,
                             input logic [63:0] dat0, input bit rand_dat,
                             input logic [7:0] sel0, input bit rand_sel,
                             output logic [63:0] last_dat, output bit got_err);
        int          words[16];
        logic [63:0] wd[16];
        logic [7:0]  ws[16];
        int          err_at, b, waits, cyc_n, n_ok, wr0, rd0;
        bit          first, done, dropped, acked_now;
        logic [2:0]  cti;

        err_at   = -1;
        words[0] = int'(adr0 >> 3);
        for (int i = 0; i < beats; i++) begin
            if (i > 0) words[i] = next_word(words[i-1], bte_v);
            if (err_at < 0 && words[i] >= DEPTH) err_at = i;
            wd[i] = rand_dat ? {$urandom, $urandom} : dat0 + 64'(i);
            ws[i] = rand_sel ? 8'($urandom_range(0, 255)) : sel0;
        end
        n_ok = (err_at < 0) ? beats : err_at;
        if (!we_v)
            for (int i = 0; i < n_ok; i++) exp_q.push_back(model_mem[words[i]]);

        wr0 = wr_count; rd0 = rd_count;
        b = 0; waits = 0; first = 1; done = 0; dropped = 0; cyc_n = 0;
        got_err = 0; last_dat = '0;
        wb_if.wb_cyc_i = 1'b1;
        wb_if.wb_stb_i = 1'b1;
        wb_if.wb_we_i  = we_v;
        wb_if.wb_bte_i = bte_v;
        cti = (beats == 1) ? CTI_CLASSIC : CTI_INCR;
        set_beat(words[0], wd[0], ws[0], cti);

        while (!done && cyc_n < 100) begin
            @(negedge HCLK);
            cyc_n++;
            acked_now = 0;
            chk({nm, " ack_err_excl"}, 64'(wb_if.wb_ack_o & wb_if.wb_err_o), 64'd0);
            if (wb_if.wb_ack_o) begin
                chk({nm, " wait"}, 64'(waits), first ? 64'd1 : 64'd0);
                if (!we_v) begin
                    if (exp_q.size() == 0) chk({nm, " rdata_extra"}, 64'd1, 64'd0);
                    else chk({nm, " rdata"}, wb_if.wb_dat_o, exp_q.pop_front());
                    last_dat = wb_if.wb_dat_o;
                end else begin
                    for (int k = 0; k < SW; k++)
                        if (ws[b][k]) model_mem[words[b]][8*k +: 8] = wd[b][8*k +: 8];
                end
                b++; waits = 0; first = 0; acked_now = 1;
                if (b == beats) done = 1;
            end else if (wb_if.wb_err_o) begin
                chk({nm, " err_wait"}, 64'(waits), first ? 64'd1 : 64'd0);
                got_err = 1;
                done    = 1;
            end else begin
                waits++;
            end
            @(posedge HCLK); #1;
            if (!done) begin
                if (acked_now && b == drop_after && !dropped) begin
                    wb_if.wb_stb_i = 1'b0;
                    dropped = 1;
                    repeat (2) begin
                        @(negedge HCLK);
                        chk({nm, " drop_quiet"}, 64'({wb_if.wb_ack_o, wb_if.wb_err_o}), 64'd0);
                        @(posedge HCLK); #1;
                    end
                    wb_if.wb_stb_i = 1'b1;
                    first = 1; waits = 0;
                end
                cti = (b == beats - 1) ? CTI_EOB : CTI_INCR;
                set_beat(words[b], wd[b], ws[b], cti);
            end
        end
        chk({nm, " timeout"}, 64'(done), 64'd1);
        wb_if.wb_cyc_i = 1'b0;
        wb_if.wb_stb_i = 1'b0;
        wb_if.wb_cti_i = CTI_CLASSIC;

        chk({nm, " n_acks"}, 64'(b), 64'(n_ok));
        chk({nm, " err_seen"}, 64'(got_err), 64'(err_at >= 0));
        chk({nm, " idle_after"}, 64'(dbg_state), 64'(WB_IDLE));
        if (we_v) begin
            chk({nm, " n_writes"}, 64'(wr_count - wr0), 64'(b));
            for (int i = 0; i < b; i++)
                chk({nm, " mem"}, sram[words[i]], model_mem[words[i]]);
        end
        if (err_at == 0)
            chk({nm, " no_mem_access"}, 64'((wr_count - wr0) + (rd_count - rd0)), 64'd0);
        chk({nm, " exp_q_empty"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [7:0]  sel;
        logic [63:0] dat;
        bit          exp_err;
        bit          chk_dat;
        logic [63:0] exp_dat;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [63:0] last;
        logic [63:0] p;
        bit          gerr;
        int          acks, n, w, drop, beats;
        logic        we_r;
        logic [1:0]  bte_r;

        for (int i = 0; i < DEPTH; i++) model_mem[i] = pre_val(i);
        p = pre_val(4);
        vecs[0] = '{1'b0, 32'h018, 8'hFF, 64'd0, 1'b0, 1'b1, 64'h0000_0000_DEAD_BEEF};
        vecs[1] = '{1'b1, 32'h020, 8'h0F, 64'h1122_3344_5566_7788, 1'b0, 1'b0, 64'd0};
        vecs[2] = '{1'b0, 32'h020, 8'hFF, 64'd0, 1'b0, 1'b1, {p[63:32], 32'h5566_7788}};
        vecs[3] = '{1'b0, 32'h200, 8'hFF, 64'd0, 1'b1, 1'b0, 64'd0};
        vecs[4] = '{1'b1, 32'h208, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 64'd0};
        vecs[5] = '{1'b1, 32'h028, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 64'd0};
        vecs[6] = '{1'b0, 32'h028, 8'hFF, 64'd0, 1'b0, 1'b1, pre_val(5)};
        vecs[7] = '{1'b0, 32'h1F8, 8'hFF, 64'd0, 1'b0, 1'b1, pre_val(63)};
        vecs[8] = '{1'b0, 32'h01F, 8'hFF, 64'd0, 1'b0, 1'b1, 64'h0000_0000_DEAD_BEEF};

        // Reset with a live in-range read request: nothing may leak out.
        HRESETn = 1'b0;
        do_preload = 1'b1;
        wb_if.wb_cyc_i = 1'b1; wb_if.wb_stb_i = 1'b1; wb_if.wb_we_i = 1'b0;
        wb_if.wb_adr_i = 32'h18; wb_if.wb_dat_i = '0; wb_if.wb_sel_i = 8'hFF;
        wb_if.wb_cti_i = CTI_CLASSIC; wb_if.wb_bte_i = BTE_LINEAR;
        repeat (3) @(posedge HCLK);
        #1;
        do_preload = 1'b0;
        chk("rst ack", 64'(wb_if.wb_ack_o), 64'd0);
        chk("rst err", 64'(wb_if.wb_err_o), 64'd0);
        chk("rst rty", 64'(wb_if.wb_rty_o), 64'd0);
        chk("rst dat", wb_if.wb_dat_o, 64'd0);
        chk("rst mem_req", 64'(mem_req), 64'd0);
        chk("rst mem_adr", 64'(mem_adr), 64'd0);
        chk("rst state", 64'(dbg_state), 64'(WB_IDLE));
        wb_if.wb_cyc_i = 1'b0; wb_if.wb_stb_i = 1'b0;
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        @(posedge HCLK); #1;

        for (int i = 0; i < 9; i++) begin
            run_burst($sformatf("vec%0d", i), vecs[i].we, vecs[i].adr, BTE_LINEAR, 1, -1,
                      vecs[i].dat, 1'b0, vecs[i].sel, 1'b0, last, gerr);
            chk($sformatf("vec%0d err", i), 64'(gerr), 64'(vecs[i].exp_err));
            if (vecs[i].chk_dat) chk($sformatf("vec%0d dat", i), last, vecs[i].exp_dat);
        end
        chk("vec1 sram4", sram[4], {p[63:32], 32'h5566_7788});

        // Wrap-4 read from index 7: 7,4,5,6.
        run_burst("wrap4", 1'b0, 32'h38, BTE_WRAP4, 4, -1, 64'd0, 1'b0, 8'hFF, 1'b0, last, gerr);
        chk("wrap4 last", last, pre_val(6));

        // Linear 8-beat write burst from 0.
        run_burst("wburst8", 1'b1, 32'h0, BTE_LINEAR, 8, -1, 64'hA0A0_0000_0000_0000, 1'b0,
                  8'hFF, 1'b0, last, gerr);
        for (int i = 0; i < 8; i++)
            chk($sformatf("wburst8 mem%0d", i), sram[i], 64'hA0A0_0000_0000_0000 + 64'(i));

        // Strobe dropped after two beats, then resumed.
        run_burst("drop", 1'b0, 32'h80, BTE_LINEAR, 6, 2, 64'd0, 1'b0, 8'hFF, 1'b0, last, gerr);
        chk("drop last", last, pre_val(21));

        // Linear burst running off the top of the array.
        run_burst("overflow", 1'b0, 32'h1F0, BTE_LINEAR, 4, -1, 64'd0, 1'b0, 8'hFF, 1'b0, last, gerr);
        chk("overflow err", 64'(gerr), 64'd1);
        chk("overflow last", last, pre_val(63));

        run_burst("wrap16", 1'b0, 32'h168, BTE_WRAP16, 5, -1, 64'd0, 1'b0, 8'hFF, 1'b0, last, gerr);
        chk("wrap16 last", last, pre_val(33));

        // Reset asserted in the middle of a read burst.
        wb_if.wb_cyc_i = 1'b1; wb_if.wb_stb_i = 1'b1; wb_if.wb_we_i = 1'b0;
        wb_if.wb_adr_i = 32'h100; wb_if.wb_bte_i = BTE_LINEAR; wb_if.wb_cti_i = CTI_INCR;
        acks = 0; n = 0;
        while (acks < 2 && n < 20) begin
            @(negedge HCLK);
            n++;
            if (wb_if.wb_ack_o) acks++;
            @(posedge HCLK); #1;
        end
        chk("midrst acks", 64'(acks), 64'd2);
        HRESETn = 1'b0;
        #1;
        chk("midrst ack", 64'(wb_if.wb_ack_o), 64'd0);
        chk("midrst err", 64'(wb_if.wb_err_o), 64'd0);
        chk("midrst dat", wb_if.wb_dat_o, 64'd0);
        chk("midrst mem_req", 64'(mem_req), 64'd0);
        chk("midrst mem_we", 64'(mem_we), 64'd0);
        chk("midrst state", 64'(dbg_state), 64'(WB_IDLE));
        wb_if.wb_cyc_i = 1'b0; wb_if.wb_stb_i = 1'b0; wb_if.wb_cti_i = CTI_CLASSIC;
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        repeat (3) begin
            @(negedge HCLK);
            chk("postrst quiet", 64'({wb_if.wb_ack_o, wb_if.wb_err_o, mem_req}), 64'd0);
        end
        @(posedge HCLK); #1;

        // Random bursts against the word-level model.
        for (int t = 0; t < 40; t++) begin
            we_r  = 1'($urandom_range(0, 1));
            bte_r = 2'($urandom_range(0, 3));
            beats = $urandom_range(1, 8);
            case ($urandom_range(0, 7))
                0:       w = DEPTH + $urandom_range(0, 63);
                1:       w = DEPTH - $urandom_range(1, 4);
                default: w = $urandom_range(0, DEPTH - 1);
            endcase
            drop = (beats > 2 && $urandom_range(0, 3) == 0) ? $urandom_range(1, beats - 1) : -1;
            run_burst($sformatf("rnd%0d", t), we_r, 32'(w * 8 + $urandom_range(0, 7)), bte_r,
                      beats, drop, 64'd0, 1'b1, 8'h00, 1'b1, last, gerr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
